// File: rtl/aes_key_expander.sv
// AES key-schedule engine for AES-128/192/256.
// Produces one 32-bit schedule word per clock into an internal round-key
// buffer and serves complete round keys through a registered read port.
// Round keys already written may be read while expansion continues.
module aes_key_expander #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                key_ready,
    output logic [3:0]          rk_count,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_i;            // index of next word to write == words written
    logic [2:0]   r_mod;          // r_i mod NK
    logic [3:0]   r_rcon;         // Rcon table index
    logic         r_done;
    logic         r_key_ready;
    logic [127:0] r_rk_out_p1;
    logic [31:0]  r_w [0:NW-1];

    logic         w_load;
    logic         w_exp_we;
    logic         w_last;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic [127:0] w_rdata;
    logic [31:0]  w_key_w [0:7];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Cipher key split into words, w[0] in the MSBs; unused slots padded
    for (genvar g = 0; g < 8; g++) begin : g_key
        if (g < NK) begin : g_used
            assign w_key_w[g] = key_in[KEY_BITS-1-32*g -: 32];
        end else begin : g_pad
            assign w_key_w[g] = 32'h0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_exp_we    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_exp_we = 1'b1;
                if (r_i == 6'(NW - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Schedule word datapath: w[i] = w[i-Nk] ^ f(w[i-1])
    always_comb begin
        w_prev   = r_w[r_i - 6'd1];
        w_back   = r_w[r_i - 6'(NK)];
        w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub    = sub_word(w_sub_in);
        w_temp   = w_prev;
        if (r_mod == 3'd0)
            w_temp = w_sub ^ {rcon(r_rcon), 24'h0};
        else if (NK == 8 && r_mod == 3'd4)
            w_temp = w_sub;
        w_new = w_back ^ w_temp;
    end

    // Control counters and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i         <= 6'd0;
            r_mod       <= 3'd0;
            r_rcon      <= 4'd0;
            r_done      <= 1'b0;
            r_key_ready <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_i         <= 6'(NK);
                r_mod       <= 3'd0;
                r_rcon      <= 4'd0;
                r_key_ready <= 1'b0;
            end else if (w_exp_we) begin
                r_i   <= r_i + 6'd1;
                r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0) r_rcon <= r_rcon + 4'd1;
                if (w_last) r_key_ready <= 1'b1;
            end
        end
    end

    // Round-key buffer writes: key words on start, then one word per cycle
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < NK; k++) r_w[6'(k)] <= w_key_w[3'(k)];
        end else if (w_exp_we) begin
            r_w[r_i] <= w_new;
        end
    end

    // Read words, forwarding any word being written on this same edge
    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [5:0]  w_addr;
        logic [31:0] w_word;
        assign w_addr = {rk_idx, 2'b00} + 6'(k);
        always_comb begin
            w_word = r_w[w_addr];
            if (w_exp_we && (w_addr == r_i)) w_word = w_new;
            if (w_load && (w_addr < 6'(NK)))  w_word = w_key_w[w_addr[2:0]];
        end
    end
    assign w_rdata = {g_rd[0].w_word, g_rd[1].w_word, g_rd[2].w_word, g_rd[3].w_word};

    // Registered read port; out-of-range index reads as zero
    always_ff @(posedge clk) begin
        if (rst)                     r_rk_out_p1 <= 128'h0;
        else if (rk_idx > 4'(NR))    r_rk_out_p1 <= 128'h0;
        else                         r_rk_out_p1 <= w_rdata;
    end

    assign busy      = (r_state == S_EXPAND);
    assign done      = r_done;
    assign key_ready = r_key_ready;
    assign rk_count  = r_i[5:2];
    assign rk_out    = r_rk_out_p1;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: one instance per key size, FIPS-197 vectors,
// early reads, ignored start, mid-run reset and back-to-back expansion.
module tb_aes_key_expander;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         st    [3];
    logic [255:0] key_v [3];
    logic [3:0]   idx   [3];
    logic         bsy   [3];
    logic         dn    [3];
    logic         kr    [3];
    logic [3:0]   cnt   [3];
    logic [127:0] rko   [3];
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;

    assign k128 = key_v[0][255:128];
    assign k192 = key_v[1][255:64];
    assign k256 = key_v[2];

    aes_key_expander #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .rst(rst), .start(st[0]), .key_in(k128), .busy(bsy[0]), .done(dn[0]),
        .key_ready(kr[0]), .rk_count(cnt[0]), .rk_idx(idx[0]), .rk_out(rko[0]));
    aes_key_expander #(.KEY_BITS(192)) u_aes192 (
        .clk(clk), .rst(rst), .start(st[1]), .key_in(k192), .busy(bsy[1]), .done(dn[1]),
        .key_ready(kr[1]), .rk_count(cnt[1]), .rk_idx(idx[1]), .rk_out(rko[1]));
    aes_key_expander #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .rst(rst), .start(st[2]), .key_in(k256), .busy(bsy[2]), .done(dn[2]),
        .key_ready(kr[2]), .rk_count(cnt[2]), .rk_idx(idx[2]), .rk_out(rko[2]));

    typedef struct {
        int           s;
        logic [3:0]   j;
        logic [127:0] e;
        string        nm;
    } vec_t;

    typedef struct {
        string        nm;
        logic [127:0] v;
    } exp_t;

    vec_t vt   [$];
    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input int s, input logic [3:0] j, input logic [127:0] e, input string nm);
        vec_t v;
        v.s = s; v.j = j; v.e = e; v.nm = nm;
        vt.push_back(v);
    endtask

    // Called and returning at posedge+1; expectation queued when idx is driven
    task automatic rd(input int s, input logic [3:0] j, input logic [127:0] e, input string nm);
        exp_t x;
        idx[s] = j;
        x.nm = nm; x.v = e;
        sb_q.push_back(x);
        @(posedge clk); #1;
        x = sb_q.pop_front();
        chk(x.nm, rko[s], x.v);
    endtask

    // Starts an expansion and returns at posedge+1 in the done cycle
    task automatic run(input int s, input logic [255:0] key, input int lat, input int cnt0,
                       input int nrk, input string nm);
        int n;
        key_v[s] = key;
        st[s] = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
        chk({nm, "_cnt_after_start"}, 128'(cnt[s]), 128'(cnt0));
        chk({nm, "_busy_after_start"}, 128'(bsy[s]), 128'd1);
        n = 0;
        while (n < 200 && !dn[s]) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_latency"}, 128'(n), 128'(lat));
        chk({nm, "_key_ready"}, 128'(kr[s]), 128'd1);
        chk({nm, "_busy_at_done"}, 128'(bsy[s]), 128'd0);
        chk({nm, "_rk_count_final"}, 128'(cnt[s]), 128'(nrk));
    endtask

    initial begin
        int   n;
        int   got2;
        int   n_done;
        bit   pend;
        exp_t x;

        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            st[s] = 1'b0; key_v[s] = '0; idx[s] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_busy%0d", s), 128'(bsy[s]), 128'd0);
            chk($sformatf("rst_done%0d", s), 128'(dn[s]), 128'd0);
            chk($sformatf("rst_key_ready%0d", s), 128'(kr[s]), 128'd0);
            chk($sformatf("rst_rk_count%0d", s), 128'(cnt[s]), 128'd0);
            chk($sformatf("rst_rk_out%0d", s), rko[s], 128'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        add(0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "a1_rk0");
        add(0, 4'd1,  A1_RK1,                                "a1_rk1");
        add(0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "a1_rk2");
        add(0, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, "a1_rk3");
        add(0, 4'd9,  128'hac7766f319fadc2128d12941575c006e, "a1_rk9");
        add(0, 4'd10, A1_RK10,                               "a1_rk10");
        add(1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, "a2_rk0");
        add(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "a2_rk12");
        add(2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "a3_rk0");
        add(2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "a3_rk1");
        add(2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, "a3_rk2");
        add(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "a3_rk14");

        run(0, KEY128, 40, 1, 11, "a1");
        run(1, KEY192, 46, 1, 13, "a2");
        run(2, KEY256, 52, 2, 15, "a3");

        foreach (vt[v]) rd(vt[v].s, vt[v].j, vt[v].e, vt[v].nm);

        rd(0, 4'd11, 128'h0, "oor128_idx11");
        rd(0, 4'd15, 128'h0, "oor128_idx15");
        rd(1, 4'd13, 128'h0, "oor192_idx13");
        rd(2, 4'd15, 128'h0, "oor256_idx15");

        // Early read as soon as rk_count reaches 2, plus a start while busy
        key_v[0] = KEY128;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        n = 0; got2 = -1; pend = 1'b0;
        while (n < 200 && !dn[0]) begin
            if (cnt[0] == 4'd2 && got2 < 0) begin
                got2 = n;
                idx[0] = 4'd1;
                x.nm = "early_rk1"; x.v = A1_RK1;
                sb_q.push_back(x);
                pend = 1'b1;
            end else if (n == 15) begin
                st[0] = 1'b1;
                key_v[0] = '0;
            end
            @(posedge clk); #1;
            n++;
            st[0] = 1'b0;
            if (pend) begin
                x = sb_q.pop_front();
                chk(x.nm, rko[0], x.v);
                pend = 1'b0;
            end
            if (n == 16) chk("busy_after_ignored_start", 128'(bsy[0]), 128'd1);
        end
        chk("early_rk_count2_cycle", 128'(got2), 128'd4);
        chk("ignored_start_latency", 128'(n), 128'd40);
        rd(0, 4'd10, A1_RK10, "ignored_start_rk10");
        rd(0, 4'd1,  A1_RK1,  "ignored_start_rk1");

        // Reset 20 cycles into an expansion
        key_v[0] = KEY128;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 128'(bsy[0]), 128'd0);
        chk("midrst_key_ready", 128'(kr[0]), 128'd0);
        chk("midrst_rk_count", 128'(cnt[0]), 128'd0);
        chk("midrst_done", 128'(dn[0]), 128'd0);
        chk("midrst_rk_out", rko[0], 128'd0);
        rst = 1'b0;
        n_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (dn[0] || bsy[0]) n_done++;
        end
        chk("midrst_no_done_after", 128'(n_done), 128'd0);

        // All-zero key, then A.1 started in the done cycle
        run(0, 256'h0, 40, 1, 11, "zero");
        key_v[0] = KEY128;
        st[0] = 1'b1;
        idx[0] = 4'd1;
        x.nm = "b2b_zero_rk1"; x.v = 128'h62636363626363636263636362636363;
        sb_q.push_back(x);
        @(posedge clk); #1;
        st[0] = 1'b0;
        x = sb_q.pop_front();
        chk(x.nm, rko[0], x.v);
        chk("b2b_key_ready_drop", 128'(kr[0]), 128'd0);
        chk("b2b_busy", 128'(bsy[0]), 128'd1);
        chk("b2b_done_clear", 128'(dn[0]), 128'd0);
        chk("b2b_rk_count", 128'(cnt[0]), 128'd1);
        n = 0;
        while (n < 200 && !kr[0]) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_key_ready_latency", 128'(n), 128'd40);
        rd(0, 4'd10, A1_RK10, "b2b_rk10");
        rd(0, 4'd1,  A1_RK1,  "b2b_rk1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised AES key-schedule engine generating all round keys for AES-128, AES-192 or AES-256 from a cipher key, one 32-bit schedule word per clock. It stores the schedule in an internal round-key buffer and serves it through a registered read port. It is the shared key-expansion stage for the next-generation AES datapath, replacing per-core inline expansion, and allows round keys to be consumed while expansion is still running.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256 (anything else is an elaboration error).
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to expand `key_in`; ignored while `busy`=1.
- key_in  input  KEY_BITS  cipher key; word w[0] = key_in[KEY_BITS-1 -: 32]; sampled only on the accepted `start` cycle.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse marking the final word written.
- key_ready  output  1  full schedule valid; held until the next accepted `start` or `rst`.
- rk_count  output  4  number of complete round keys (0..Nr+1) currently readable.
- rk_idx  input  4  round-key index to read, 0..Nr.
- rk_out  output  128  registered round key rk_idx: {w[4j], w[4j+1], w[4j+2], w[4j+3]}, w[4j] in MSBs.

## Operation
- Derived constants: Nk = KEY_BITS/32 (4/6/8); Nr = Nk+6 (10/12/14); W = 4·(Nr+1) (44/52/60) words.
- FSM states: IDLE, EXPAND.
  - IDLE → EXPAND on `start`: load w[0..Nk-1] from `key_in`, set word counter i = Nk, Rcon index = 0, `busy`=1, `key_ready`=0.
  - In EXPAND, one word per cycle: temp = w[i-1]; if i mod Nk == 0, temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0} and Rcon index advances; else if Nk == 8 and i mod Nk == 4, temp = SubWord(temp); w[i] = w[i-Nk] ^ temp; i++.
  - EXPAND → IDLE after writing w[W-1]: `busy`=0, `key_ready`=1, `done`=1 for one cycle.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. AES-256 uses the first 7 entries and AES-192 the first 8.
- SubWord uses the FIPS-197 S-box on each byte. Implementation may choose ROM or GF(2^8)-inverse logic, but it must be combinational within the cycle.
- rk_count = floor(words written / 4). It updates with each word write and reaches Nr+1 at `done`.
- A round key j with j < rk_count is valid to read even while `busy`=1.
- Read of an index j ≥ rk_count while `busy`=1 returns don't-care data.
- Read of an index rk_idx > Nr returns 128'h0.
- `start` asserted while `busy`=1 is dropped with no effect; the current expansion is unaffected.
- `start` in IDLE with `key_ready`=1 restarts expansion and invalidates the previous schedule (`key_ready`→0, rk_count→Nk/4 rounded down).

## Timing
- Reset values: busy=0, done=0, key_ready=0, rk_count=0, rk_out=128'h0. FSM goes to IDLE; buffer contents are don't-care.
- Reset mid-EXPAND aborts at the next edge with the outputs above. No `done` pulse follows.
- Let start be sampled at edge T. Key words are written at edge T. Word w[Nk+k] is written at edge T+1+k.
- The final word is written at edge T+W-Nk, which is T+40 (128), T+46 (192) or T+52 (256).
- `done` and `key_ready` are high after edge T+W-Nk. `done` clears at the next edge.
- rk_count after edge T is 1 (Nk=4,6) or 2 (Nk=8).
- Read latency is 1 cycle: rk_idx sampled at edge E gives rk_out valid after E.
- A round-key read whose last word is written at edge E may be requested at E or later.
- `start` is accepted back-to-back when presented in the cycle `done` is high: the FSM is IDLE then, so the new expansion begins at that edge.

## Test plan
- **AES-128, FIPS-197 A.1.**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `done` 40 cycles after start.
  - Required: rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- **AES-192, FIPS-197 A.2.**
  - Stimulus: KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Required: `done` after 46 cycles; rk_idx=12 → e98ba06f448c773c8ecc720401002202.
- **AES-256, FIPS-197 A.3.**
  - Stimulus: KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Required: `done` after 52 cycles; rk_idx=14 → fe4890d1e6188d0b046df344706c631e. This exercises the i mod 8 == 4 SubWord path.
- **Early read and start while busy (AES-128).**
  - Stimulus: read rk_idx=1 as soon as rk_count=2; pulse `start` with a different key mid-expansion.
  - Required: early read returns a0fafe17…6c7605; the second start is ignored and the final schedule still matches A.1.
- **Reset and out-of-range index.**
  - Stimulus: assert `rst` at cycle 20 of an expansion; then read rk_idx=11 after a full AES-128 run.
  - Required: after reset, busy=0, key_ready=0, rk_count=0 and no `done` pulse; the rk_idx=11 read returns 128'h0.
- **Back-to-back expansions.**
  - Stimulus: issue a new `start` in the `done` cycle with the A.1 key after a run with an all-zero key.
  - Required: `key_ready` drops, then rises again 40 cycles later with the A.1 schedule.
